// File: rtl/sr_arb_pkg.sv
// Shared types, SR op encodings and the round-robin pick helper for the SR flag arbiter.
package sr_arb_pkg;

  localparam int unsigned MAX_REQ = 8;
  localparam int unsigned PTR_W   = 3;

  typedef enum logic [0:0] {
    IDLE,
    APPLY
  } state_e;

  // Encoding is {S,R}
  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_CLR  = 2'b01;
  localparam logic [1:0] OP_SET  = 2'b10;
  localparam logic [1:0] OP_INV  = 2'b11;

  // First active requester found searching upward from ptr+1, wrapping at nreq.
  function automatic logic [PTR_W-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                               input logic [PTR_W-1:0]   ptr,
                                               input int unsigned        nreq);
    logic [PTR_W-1:0] win;
    logic             found;
    int unsigned      cand;
    win   = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= MAX_REQ; i++) begin
      if (i <= nreq) begin
        cand = (32'(ptr) + i) % nreq;
        if (!found && req[cand[PTR_W-1:0]]) begin
          win   = cand[PTR_W-1:0];
          found = 1'b1;
        end
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/sr_flag_bank.sv
// Bank of SR flag bits; clr_all wins over a write, out-of-range indices write nothing.
module sr_flag_bank
  import sr_arb_pkg::*;
#(
  parameter int unsigned NFLAG = 8,
  parameter int unsigned IDX_W = (NFLAG > 1) ? $clog2(NFLAG) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             s,
  input  logic             r,
  input  logic             clr_all,
  output logic [NFLAG-1:0] flags
);

  logic [NFLAG-1:0] flags_q, flags_d;

  always_comb begin
    flags_d = flags_q;
    if (clr_all) begin
      flags_d = '0;
    end else if (wr_en) begin
      for (int i = 0; i < NFLAG; i++) begin
        if (wr_idx == IDX_W'(i)) begin
          unique case ({s, r})
            OP_SET:          flags_d[i] = 1'b1;
            OP_CLR:          flags_d[i] = 1'b0;
            OP_HOLD, OP_INV: flags_d[i] = flags_q[i];
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= '0;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign flags = flags_q;

endmodule

// File: rtl/sr_flag_arbiter.sv
// Round-robin arbiter serialising SR set/clear/hold requests onto a shared flag bank.
module sr_flag_arbiter
  import sr_arb_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned NFLAG = 8,
  localparam int unsigned IDX_W = (NFLAG > 1) ? $clog2(NFLAG) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       op_s,
  input  logic [NREQ-1:0]       op_r,
  input  logic [NREQ*IDX_W-1:0] idx,
  input  logic                  clr_all,
  output logic [NREQ-1:0]       gnt,
  output logic                  err,
  output logic                  busy,
  output logic [NFLAG-1:0]      flags
);

  localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(NREQ - 1);

  state_e           state_q, state_d;
  logic [PTR_W-1:0] rr_q, rr_d;
  logic [PTR_W-1:0] win_q, win_d;
  logic             s_q, s_d, r_q, r_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             op_bad, idx_bad;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    win_d   = win_q;
    s_d     = s_q;
    r_d     = r_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          win_d = rr_pick(MAX_REQ'(req), rr_q, NREQ);
          for (int k = 0; k < NREQ; k++) begin
            if (win_d == PTR_W'(k)) begin
              s_d   = op_s[k];
              r_d   = op_r[k];
              idx_d = idx[k*IDX_W +: IDX_W];
            end
          end
          state_d = APPLY;
        end
      end
      APPLY: begin
        rr_d    = win_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= PTR_RST;
      win_q   <= '0;
      s_q     <= 1'b0;
      r_q     <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      win_q   <= win_d;
      s_q     <= s_d;
      r_q     <= r_d;
      idx_q   <= idx_d;
    end
  end

  // Outputs decode straight from state so an async reset clears them at once.
  always_comb begin
    busy    = (state_q == APPLY);
    op_bad  = ({s_q, r_q} == OP_INV);
    idx_bad = (32'(idx_q) >= NFLAG);
    err     = busy && (op_bad || idx_bad);
    gnt     = '0;
    for (int k = 0; k < NREQ; k++) begin
      gnt[k] = busy && (win_q == PTR_W'(k));
    end
  end

  sr_flag_bank #(
    .NFLAG (NFLAG),
    .IDX_W (IDX_W)
  ) u_bank (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (busy),
    .wr_idx  (idx_q),
    .s       (s_q),
    .r       (r_q),
    .clr_all (clr_all),
    .flags   (flags)
  );

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Directed bench for sr_flag_arbiter: 8-flag and 6-flag instances share stimulus, checked
// every cycle against a transaction-level model plus hand-computed literals.
module tb_sr_flag_arbiter;

  localparam int NREQ  = 4;
  localparam int IDX_W = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ-1:0]   op_s = '0;
  logic [NREQ-1:0]   op_r = '0;
  logic [NREQ*3-1:0] idx = '0;
  logic              clr_all = 1'b0;

  logic [NREQ-1:0] gnt_a, gnt_b;
  logic            err_a, err_b, busy_a, busy_b;
  logic [7:0]      flags_a;
  logic [5:0]      flags_b;

  int n_tests = 0;
  int n_fail  = 0;

  // Transaction-level model: one pending grant, last-served requester, flag images.
  bit       m_pend;
  int       m_win, m_last, m_idx;
  bit       m_s, m_r;
  bit [7:0] m_fa;
  bit [5:0] m_fb;

  sr_flag_arbiter #(.NREQ(NREQ), .NFLAG(8)) dut_a (
    .clk (clk), .rst (rst), .req (req), .op_s (op_s), .op_r (op_r), .idx (idx),
    .clr_all (clr_all), .gnt (gnt_a), .err (err_a), .busy (busy_a), .flags (flags_a)
  );

  sr_flag_arbiter #(.NREQ(NREQ), .NFLAG(6)) dut_b (
    .clk (clk), .rst (rst), .req (req), .op_s (op_s), .op_r (op_r), .idx (idx),
    .clr_all (clr_all), .gnt (gnt_b), .err (err_b), .busy (busy_b), .flags (flags_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = 1'b0;
    m_win  = 0;
    m_last = NREQ - 1;
    m_s    = 1'b0;
    m_r    = 1'b0;
    m_idx  = 0;
    m_fa   = '0;
    m_fb   = '0;
  endtask

  task automatic model_compare();
    logic [NREQ-1:0] eg;
    eg = m_pend ? NREQ'(1 << m_win) : '0;
    chk("cyc gnt_a", gnt_a, eg);
    chk("cyc gnt_b", gnt_b, eg);
    chk("cyc busy_a", busy_a, m_pend);
    chk("cyc busy_b", busy_b, m_pend);
    chk("cyc err_a", err_a, m_pend && ((m_s && m_r) || m_idx >= 8));
    chk("cyc err_b", err_b, m_pend && ((m_s && m_r) || m_idx >= 6));
    chk("cyc flags_a", flags_a, m_fa);
    chk("cyc flags_b", flags_b, m_fb);
  endtask

  // Inputs are stable from here to the next rising edge, so they are what it samples.
  task automatic model_step();
    bit found;
    int c;
    if (m_pend) begin
      if (m_s != m_r) begin
        if (m_idx < 8) m_fa[m_idx] = m_s;
        if (m_idx < 6) m_fb[m_idx] = m_s;
      end
      m_last = m_win;
      m_pend = 1'b0;
    end else begin
      found = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
        c = (m_last + k) % NREQ;
        if (!found && req[c]) begin
          found  = 1'b1;
          m_pend = 1'b1;
          m_win  = c;
          m_s    = op_s[c];
          m_r    = op_r[c];
          m_idx  = int'(idx[c*3 +: 3]);
        end
      end
    end
    if (clr_all) begin
      m_fa = '0;
      m_fb = '0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (rst) model_reset();
    model_compare();
    if (!rst) model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input int k, input bit s, input bit r, input int ix);
    op_s[k]        = s;
    op_r[k]        = r;
    idx[k*3 +: 3]  = 3'(ix);
  endtask

  task automatic serve(input int k);
    req = NREQ'(1 << k);
    tick();
    req = '0;
    tick();
  endtask

  initial begin
    model_reset();
    #1;
    chk("reset gnt", gnt_a, 4'b0000);
    chk("reset err", err_a, 1'b0);
    chk("reset busy", busy_a, 1'b0);
    chk("reset flags", flags_a, 8'h00);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Fairness: all four held, requester k sets bit k
    for (int k = 0; k < NREQ; k++) set_cmd(k, 1'b1, 1'b0, k);
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("fair gnt", gnt_a, 32'(1 << (i % 4)));
      if (i == 4) req = '0;
      tick();
      chk("fair gap", gnt_a, 4'b0000);
      if (i == 3) chk("fair flags", flags_a, 8'h0F);
    end

    // Reset while a command sits in APPLY
    set_cmd(0, 1'b1, 1'b0, 3);
    req = 4'b0001;
    tick();
    chk("rstmid gnt before", gnt_a, 4'b0001);
    rst = 1'b1;
    #1;
    chk("rstmid gnt", gnt_a, 4'b0000);
    chk("rstmid busy", busy_a, 1'b0);
    chk("rstmid flags", flags_a, 8'h00);
    tick();
    rst = 1'b0;
    set_cmd(1, 1'b0, 1'b0, 0);
    req = 4'b0011;
    tick();
    chk("post-rst first gnt", gnt_a, 4'b0001);
    req = 4'b0010;
    tick();
    chk("post-rst flags", flags_a, 8'h08);
    tick();
    chk("hold gnt", gnt_a, 4'b0010);
    chk("hold err", err_a, 1'b0);
    req = '0;
    tick();
    chk("hold flags", flags_a, 8'h08);

    // Single requester: set then clear bit 5
    clr_all = 1'b1;
    tick();
    clr_all = 1'b0;
    chk("clr_all idle", flags_a, 8'h00);
    set_cmd(2, 1'b1, 1'b0, 5);
    req = 4'b0100;
    tick();
    chk("single gnt", gnt_a, 4'b0100);
    req = '0;
    tick();
    chk("single set", flags_a, 8'h20);
    set_cmd(2, 1'b0, 1'b1, 5);
    serve(2);
    chk("single clr", flags_a, 8'h00);

    // Invalid S=R=1, then out-of-range index on the 6-flag instance
    set_cmd(0, 1'b1, 1'b0, 1);
    serve(0);
    chk("inv pre flags", flags_a, 8'h02);
    set_cmd(0, 1'b1, 1'b1, 1);
    req = 4'b0001;
    tick();
    chk("inv gnt", gnt_a, 4'b0001);
    chk("inv err", err_a, 1'b1);
    req = '0;
    tick();
    chk("inv flags", flags_a, 8'h02);
    set_cmd(0, 1'b1, 1'b0, 7);
    req = 4'b0001;
    tick();
    chk("oor err_b", err_b, 1'b1);
    chk("oor err_a", err_a, 1'b0);
    req = '0;
    tick();
    chk("oor flags_b", flags_b, 6'h02);
    chk("inrange flags_a", flags_a, 8'h82);

    // clr_all collides with an APPLY write
    for (int b = 0; b < 8; b++) begin
      set_cmd(3, 1'b1, 1'b0, b);
      serve(3);
    end
    chk("fill flags_a", flags_a, 8'hFF);
    chk("fill flags_b", flags_b, 6'h3F);
    set_cmd(3, 1'b1, 1'b0, 0);
    req = 4'b1000;
    tick();
    chk("coll gnt", gnt_a, 4'b1000);
    req = '0;
    clr_all = 1'b1;
    tick();
    clr_all = 1'b0;
    chk("coll flags_a", flags_a, 8'h00);
    chk("coll flags_b", flags_b, 6'h00);

    // Requester drops req right after being latched
    set_cmd(1, 1'b1, 1'b0, 6);
    req = 4'b0010;
    tick();
    req = '0;
    chk("drop gnt", gnt_a, 4'b0010);
    tick();
    chk("drop flags", flags_a, 8'h40);
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
